// File: rtl/psram_qpi_responder.sv
// psram_qpi_responder: device-side model of the LY68L6400 SPI/QPI command
// subset (RSTEN, RST, enter/exit QPI, quad write 0x38, fast quad read 0xEB)
// backed by a 2^ADDR_BITS byte array. Single clock domain on mem_clk.
// Reads need WAIT_CYCLES >= 2 so the first byte is prefetched before data out.
module psram_qpi_responder #(
    parameter int unsigned ADDR_BITS   = 12,
    parameter int unsigned PAGE_BYTES  = 1024,
    parameter int unsigned WAIT_CYCLES = 6
) (
    input  logic       mem_clk,
    input  logic       rst_n,
    input  logic       mem_ce,
    input  logic [3:0] mem_sio_in,
    output logic [3:0] mem_sio_out,
    output logic       mem_sio_oe,
    output logic       qpi_mode,
    output logic       cmd_err,
    output logic       busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_WDATA  = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_RDATA  = 3'd5;
    localparam logic [2:0] S_HOLD   = 3'd6;
    localparam logic [2:0] S_IGNORE = 3'd7;

    localparam int unsigned K_W = $clog2(WAIT_CYCLES + 16);
    localparam logic [K_W-1:0] K_MAX      = '1;
    localparam logic [K_W-1:0] K_OP_SPI   = K_W'(7);
    localparam logic [K_W-1:0] K_OP_QPI   = K_W'(1);
    localparam logic [K_W-1:0] K_ADDR_END = K_W'(7);
    localparam logic [K_W-1:0] K_RD_START = K_W'(7 + WAIT_CYCLES);
    localparam logic [ADDR_BITS-1:0] PAGE_MASK = ADDR_BITS'(PAGE_BYTES - 1);

    logic [2:0]           state;
    logic [K_W-1:0]       k;
    logic [6:0]           op_sr;
    logic [7:0]           op_full;
    logic                 op_done;
    logic                 op_supported;
    logic [ADDR_BITS-5:0] addr_sr;
    logic [ADDR_BITS-1:0] addr_shift;
    logic [ADDR_BITS-1:0] addr;
    logic [ADDR_BITS-1:0] addr_inc;
    logic                 is_read;
    logic                 nib_lo;
    logic                 rsten_armed;
    logic                 qpi_pending;
    logic [3:0]           wr_hi;
    logic [7:0]           rd_byte;
    logic                 mem_we;
    logic                 rd_load;
    logic [7:0]           mem [0:(1 << ADDR_BITS) - 1];

    // Opcode assembly, address shift, page-wrapped increment and memory strobes
    always_comb begin
        op_full      = qpi_mode ? {op_sr[3:0], mem_sio_in} : {op_sr, mem_sio_in[0]};
        op_done      = (state == S_CMD) && (qpi_mode ? (k == K_OP_QPI) : (k == K_OP_SPI));
        op_supported = (op_full == 8'h66) || (op_full == 8'h99) ||
                       (!qpi_mode && (op_full == 8'h35)) ||
                       (qpi_mode && ((op_full == 8'hF5) || (op_full == 8'h38) ||
                                     (op_full == 8'hEB)));
        addr_shift   = {addr_sr, mem_sio_in};
        addr_inc     = (addr & ~PAGE_MASK) | ((addr + 1'b1) & PAGE_MASK);
        mem_we       = !mem_ce && (state == S_WDATA) && nib_lo;
        rd_load      = !mem_ce && ((state == S_WAIT) || ((state == S_RDATA) && nib_lo));
        busy         = (state != S_IDLE) && (state != S_IGNORE);
    end

    // Byte array: write on the odd nibble, prefetch read during WAIT and low nibbles
    always_ff @(posedge mem_clk) begin
        if (mem_we) begin
            mem[addr] <= {wr_hi, mem_sio_in};
        end
        if (rd_load) begin
            rd_byte <= mem[addr];
        end
    end

    // Transaction sequencer: edge counter, command decode, address and data phases
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            k           <= '0;
            op_sr       <= '0;
            addr_sr     <= '0;
            addr        <= '0;
            is_read     <= 1'b0;
            nib_lo      <= 1'b0;
            rsten_armed <= 1'b0;
            qpi_pending <= 1'b0;
            qpi_mode    <= 1'b0;
            wr_hi       <= '0;
            mem_sio_out <= '0;
            mem_sio_oe  <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            cmd_err <= 1'b0;
            if (mem_ce) begin
                // CE high ends (or aborts) the transaction; a pending 0x35 takes effect here
                state      <= S_IDLE;
                k          <= '0;
                mem_sio_oe <= 1'b0;
                if (qpi_pending) begin
                    qpi_mode    <= 1'b1;
                    qpi_pending <= 1'b0;
                end
            end else begin
                if (k != K_MAX) begin
                    k <= k + 1'b1;
                end
                case (state)
                    S_IDLE: begin
                        op_sr <= qpi_mode ? {op_sr[2:0], mem_sio_in} : {op_sr[5:0], mem_sio_in[0]};
                        state <= S_CMD;
                    end
                    S_CMD: begin
                        if (op_done) begin
                            rsten_armed <= (op_full == 8'h66);
                            if (!op_supported) begin
                                cmd_err <= 1'b1;
                                state   <= S_IGNORE;
                            end else begin
                                case (op_full)
                                    8'h99: begin
                                        if (rsten_armed) begin
                                            qpi_mode    <= 1'b0;
                                            qpi_pending <= 1'b0;
                                        end
                                        state <= S_HOLD;
                                    end
                                    8'h35: begin
                                        qpi_pending <= 1'b1;
                                        state       <= S_HOLD;
                                    end
                                    8'hF5: begin
                                        qpi_mode <= 1'b0;
                                        state    <= S_HOLD;
                                    end
                                    8'h38: begin
                                        is_read <= 1'b0;
                                        state   <= S_ADDR;
                                    end
                                    8'hEB: begin
                                        is_read <= 1'b1;
                                        state   <= S_ADDR;
                                    end
                                    default: state <= S_HOLD;
                                endcase
                            end
                        end else begin
                            op_sr <= qpi_mode ? {op_sr[2:0], mem_sio_in} : {op_sr[5:0], mem_sio_in[0]};
                        end
                    end
                    S_ADDR: begin
                        // Only the low ADDR_BITS of the 24-bit address survive the shift
                        if (k == K_ADDR_END) begin
                            addr   <= addr_shift;
                            nib_lo <= 1'b0;
                            state  <= is_read ? S_WAIT : S_WDATA;
                        end else begin
                            addr_sr <= addr_shift[ADDR_BITS-5:0];
                        end
                    end
                    S_WDATA: begin
                        if (!nib_lo) begin
                            wr_hi  <= mem_sio_in;
                            nib_lo <= 1'b1;
                        end else begin
                            addr   <= addr_inc;
                            nib_lo <= 1'b0;
                        end
                    end
                    S_WAIT: begin
                        if (k == K_RD_START) begin
                            mem_sio_oe  <= 1'b1;
                            mem_sio_out <= rd_byte[7:4];
                            addr        <= addr_inc;
                            nib_lo      <= 1'b1;
                            state       <= S_RDATA;
                        end
                    end
                    S_RDATA: begin
                        // addr already points at the next byte; it is fetched alongside the low nibble
                        if (nib_lo) begin
                            mem_sio_out <= rd_byte[3:0];
                            nib_lo      <= 1'b0;
                        end else begin
                            mem_sio_out <= rd_byte[7:4];
                            addr        <= addr_inc;
                            nib_lo      <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_psram_qpi_responder.sv
// Directed bench for psram_qpi_responder: stimulus pushes expected read nibbles
// into a queue, a negedge monitor pops and compares whenever mem_sio_oe is high.
module tb_psram_qpi_responder;

    localparam int unsigned WAITC = 6;

    logic       mem_clk = 1'b0;
    logic       rst_n;
    logic       mem_ce;
    logic [3:0] mem_sio_in;
    logic [3:0] mem_sio_out;
    logic       mem_sio_oe;
    logic       qpi_mode;
    logic       cmd_err;
    logic       busy;

    int         n_checks   = 0;
    int         n_pass     = 0;
    int         err_pulses = 0;
    logic [3:0] exp_q[$];

    psram_qpi_responder #(
        .ADDR_BITS  (12),
        .PAGE_BYTES (1024),
        .WAIT_CYCLES(WAITC)
    ) dut (
        .mem_clk    (mem_clk),
        .rst_n      (rst_n),
        .mem_ce     (mem_ce),
        .mem_sio_in (mem_sio_in),
        .mem_sio_out(mem_sio_out),
        .mem_sio_oe (mem_sio_oe),
        .qpi_mode   (qpi_mode),
        .cmd_err    (cmd_err),
        .busy       (busy)
    );

    always #5 mem_clk = ~mem_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard monitor: every driven read nibble must match the next expected one
    always @(negedge mem_clk) begin
        if (rst_n === 1'b1 && mem_sio_oe !== 1'b0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_nibble: got 0x%0h oe=%b expected no output", mem_sio_out, mem_sio_oe);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                check("read_nibble", {28'd0, mem_sio_out}, {28'd0, e});
            end
        end
        if (cmd_err === 1'b1) err_pulses++;
    end

    task automatic drive_nib(input logic [3:0] n);
        mem_ce     = 1'b0;
        mem_sio_in = n;
        @(negedge mem_clk);
    endtask

    task automatic ce_end();
        mem_ce     = 1'b1;
        mem_sio_in = 4'h0;
        repeat (2) @(negedge mem_clk);
    endtask

    task automatic spi_bits(input logic [7:0] op);
        for (int i = 7; i >= 0; i--) drive_nib({3'b000, op[i]});
    endtask

    task automatic qpi_opc(input logic [7:0] op);
        drive_nib(op[7:4]);
        drive_nib(op[3:0]);
    endtask

    task automatic send_addr(input logic [23:0] a);
        drive_nib({1'b0, a[22:20]});
        for (int s = 16; s >= 0; s -= 4) drive_nib(a[s+:4]);
    endtask

    task automatic qpi_write(input logic [23:0] a, input logic [31:0] d, input int n_nib);
        qpi_opc(8'h38);
        send_addr(a);
        for (int i = 0; i < n_nib; i++) drive_nib(d[31-4*i -: 4]);
        ce_end();
    endtask

    task automatic qpi_read(input logic [23:0] a, input logic [31:0] d, input int n_bytes,
                            input bit check_wait);
        for (int i = 0; i < 2 * n_bytes; i++) exp_q.push_back(d[31-4*i -: 4]);
        qpi_opc(8'hEB);
        send_addr(a);
        for (int j = 8; j <= 7 + WAITC; j++) begin
            drive_nib(4'h0);
            if (check_wait) begin
                if (j < 7 + WAITC) check("oe_low_in_wait", {31'd0, mem_sio_oe}, 32'd0);
                else               check("oe_high_after_wait", {31'd0, mem_sio_oe}, 32'd1);
            end
        end
        for (int j = 0; j < 2 * n_bytes - 1; j++) drive_nib(4'h0);
        ce_end();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        mem_ce     = 1'b1;
        mem_sio_in = 4'h0;
        rst_n      = 1'b0;
        repeat (3) @(negedge mem_clk);
        check("rst_qpi_mode", {31'd0, qpi_mode}, 32'd0);
        check("rst_oe", {31'd0, mem_sio_oe}, 32'd0);
        check("rst_sio_out", {28'd0, mem_sio_out}, 32'd0);
        check("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge mem_clk);

        // SPI init: RSTEN, RST, enter QPI
        spi_bits(8'h66); ce_end();
        spi_bits(8'h99); ce_end();
        check("spi_after_rst", {31'd0, qpi_mode}, 32'd0);
        spi_bits(8'h35);
        check("qpi_before_ce_rise", {31'd0, qpi_mode}, 32'd0);
        ce_end();
        check("qpi_after_35", {31'd0, qpi_mode}, 32'd1);
        check("busy_idle", {31'd0, busy}, 32'd0);

        // RST without RSTEN is ignored; RSTEN then RST leaves QPI
        qpi_opc(8'h99); ce_end();
        check("qpi_99_unarmed", {31'd0, qpi_mode}, 32'd1);
        qpi_opc(8'h66); ce_end();
        qpi_opc(8'h99); ce_end();
        check("qpi_soft_reset", {31'd0, qpi_mode}, 32'd0);
        spi_bits(8'h35); ce_end();
        check("qpi_reenter", {31'd0, qpi_mode}, 32'd1);

        // Write/read 0x10
        qpi_write(24'h000010, 32'hABCD_0000, 4);
        qpi_read(24'h000010, 32'hABCD_0000, 2, 1'b1);

        // Burst write across the page end wraps to the page start
        qpi_write(24'h0003FE, 32'h1122_3344, 8);
        qpi_read(24'h0003FE, 32'h1122_3344, 4, 1'b0);
        qpi_read(24'h000000, 32'h3344_0000, 2, 1'b0);
        qpi_read(24'h7FF010, 32'hABCD_0000, 2, 1'b0);

        // Aborted write: only the complete byte lands
        qpi_write(24'h000020, 32'h5AC3_0000, 4);
        qpi_write(24'h000020, 32'h9670_0000, 3);
        qpi_read(24'h000020, 32'h96C3_0000, 2, 1'b0);

        // Unsupported QPI opcode
        drive_nib(4'h1);
        check("err_k0", {31'd0, cmd_err}, 32'd0);
        check("busy_in_cmd", {31'd0, busy}, 32'd1);
        drive_nib(4'h2);
        check("err_k1", {31'd0, cmd_err}, 32'd1);
        check("busy_ignored", {31'd0, busy}, 32'd0);
        drive_nib(4'h3);
        check("err_k2", {31'd0, cmd_err}, 32'd0);
        repeat (4) drive_nib(4'hF);
        ce_end();
        qpi_read(24'h000010, 32'hABCD_0000, 2, 1'b0);

        // Reset during read data phase
        exp_q.push_back(4'hA);
        exp_q.push_back(4'hB);
        qpi_opc(8'hEB);
        send_addr(24'h000010);
        for (int j = 8; j <= 7 + WAITC; j++) drive_nib(4'h0);
        drive_nib(4'h0);
        #2 rst_n = 1'b0;
        #1;
        check("midread_rst_oe", {31'd0, mem_sio_oe}, 32'd0);
        check("midread_rst_qpi", {31'd0, qpi_mode}, 32'd0);
        check("midread_rst_busy", {31'd0, busy}, 32'd0);
        mem_ce = 1'b1;
        #1 rst_n = 1'b1;
        repeat (3) @(negedge mem_clk);
        check("post_rst_qpi", {31'd0, qpi_mode}, 32'd0);
        check("post_rst_oe", {31'd0, mem_sio_oe}, 32'd0);

        repeat (4) @(negedge mem_clk);
        check("queue_drained", exp_q.size(), 32'd0);
        check("cmd_err_pulses", err_pulses, 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
